// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load wins over clear; otherwise contents hold.
// Clear drops only the valid bit, leaving the last word and PC visible.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned address_width = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     clear,
  input  logic [address_width-1:0] instr_d,
  input  logic [address_width-1:0] pc_d,
  output logic [address_width-1:0] instr_o,
  output logic [address_width-1:0] pc_o,
  output logic                     valid_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_o <= address_width'(NOP_INSTR);
      pc_o    <= '0;
      valid_o <= 1'b0;
    end else if (load) begin
      instr_o <= instr_d;
      pc_o    <= pc_d;
      valid_o <= 1'b1;
    end else if (clear) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem reads,
// buffers a response while decode stalls and squashes on taken redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          address_width = 32,
  parameter logic [address_width-1:0] RESET_PC  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PCsrc,
  input  logic [address_width-1:0] ImmOp,
  input  logic                     stall,
  output logic                     imem_req,
  output logic [address_width-1:0] imem_addr,
  input  logic                     imem_valid,
  input  logic [address_width-1:0] imem_rdata,
  output logic [address_width-1:0] instr_o,
  output logic [address_width-1:0] pc_o,
  output logic [address_width-1:0] pc_plus4_o,
  output logic                     valid_o
);

  localparam logic [address_width-1:0] INCR = address_width'(PC_INCR);

  state_t                   state_q, state_d;
  logic [address_width-1:0] pc_q, pc_d;
  logic [address_width-1:0] req_pc_q, req_pc_d;
  logic [address_width-1:0] hold_instr_q, hold_instr_d;
  logic [address_width-1:0] hold_pc_q, hold_pc_d;

  logic                     redirect;
  logic                     accept;
  logic [address_width-1:0] target;
  logic                     load;
  logic [address_width-1:0] load_instr;
  logic [address_width-1:0] load_pc;

  assign redirect   = PCsrc & valid_o;
  assign accept     = ~stall | ~valid_o;
  assign target     = pc_o + ImmOp;
  assign imem_addr  = pc_q;
  assign pc_plus4_o = pc_o + INCR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load         = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = req_pc_q;
    imem_req     = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = target;
        end else begin
          imem_req = 1'b1;
          req_pc_d = pc_q;
          pc_d     = pc_q + INCR;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          if (redirect) begin
            pc_d    = target;
            state_d = FETCH;
          end else if (accept) begin
            load    = 1'b1;
            state_d = FETCH;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = req_pc_q;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          // Response still in flight: it must be swallowed in DRAIN.
          pc_d    = target;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (accept) begin
          load       = 1'b1;
          load_instr = hold_instr_q;
          load_pc    = hold_pc_q;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = target;
        if (imem_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (rst) imem_req = 1'b0;
  end

  if_id_reg #(
    .address_width(address_width)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .clear  (redirect | accept),
    .instr_d(load_instr),
    .pc_d   (load_pc),
    .instr_o(instr_o),
    .pc_o   (pc_o),
    .valid_o(valid_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .address_width(32),
    .RESET_PC     (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PCsrc     (PCsrc),
    .ImmOp     (ImmOp),
    .stall     (stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .instr_o   (instr_o),
    .pc_o      (pc_o),
    .pc_plus4_o(pc_plus4_o),
    .valid_o   (valid_o)
  );

  // Memory: word at address a is 0xAAAA0000 + a/4 + 1; response 'lat' cycles after request.
  int unsigned lat = 1;
  int unsigned cnt = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hAAAA_0000 + (a >> 2) + 32'd1;
  endfunction

  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (rst) begin
      cnt <= 0;
    end else if (imem_req) begin
      mem_addr <= imem_addr;
      if (lat <= 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= word_at(imem_addr);
        cnt        <= 0;
      end else begin
        cnt <= lat - 1;
      end
    end else if (cnt == 1) begin
      imem_valid <= 1'b1;
      imem_rdata <= word_at(mem_addr);
      cnt        <= 0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; PCsrc = 1'b0; ImmOp = '0; stall = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc4", pc_plus4_o, 32'h4);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // A: first request
    @(negedge clk); rst = 1'b0; #1;
    chk("a_req", {31'd0, imem_req}, 32'd1);
    chk("a_addr", imem_addr, 32'h0);
    // B: response returns
    @(negedge clk); #1;
    chk("b_req", {31'd0, imem_req}, 32'd0);
    chk("b_valid", {31'd0, valid_o}, 32'd0);
    // C: first word in IF/ID, stall begins
    @(negedge clk); stall = 1'b1; #1;
    chk("c_valid", {31'd0, valid_o}, 32'd1);
    chk("c_instr", instr_o, 32'hAAAA_0001);
    chk("c_pc", pc_o, 32'h0);
    chk("c_pc4", pc_plus4_o, 32'h4);
    chk("c_req", {31'd0, imem_req}, 32'd1);
    chk("c_addr", imem_addr, 32'h4);
    // D..F: stalled, second word buffered, no requests
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, valid_o}, 32'd1);
      chk("stall_instr", instr_o, 32'hAAAA_0001);
      chk("stall_pc", pc_o, 32'h0);
    end
    // G: release stall; buffered word loads at this edge
    @(negedge clk); stall = 1'b0; #1;
    chk("g_req", {31'd0, imem_req}, 32'd0);
    chk("g_instr", instr_o, 32'hAAAA_0001);
    // H: buffered word with its own PC
    @(negedge clk); #1;
    chk("h_valid", {31'd0, valid_o}, 32'd1);
    chk("h_instr", instr_o, 32'hAAAA_0002);
    chk("h_pc", pc_o, 32'h4);
    chk("h_pc4", pc_plus4_o, 32'h8);
    chk("h_addr", imem_addr, 32'h8);
    // I..M: steady stream, bubble on alternate cycles
    @(negedge clk); #1;
    chk("i_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("j_pc", pc_o, 32'h8);
    chk("j_addr", imem_addr, 32'hC);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("l_pc", pc_o, 32'hC);
    chk("l_addr", imem_addr, 32'h10);
    @(negedge clk); #1;
    // N: pc_o=0x10, backward branch by 8
    @(negedge clk); PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8; #1;
    chk("n_valid", {31'd0, valid_o}, 32'd1);
    chk("n_pc", pc_o, 32'h10);
    chk("n_instr", instr_o, 32'hAAAA_0005);
    chk("n_req", {31'd0, imem_req}, 32'd0);
    // O: squashed, fetch resumes at target
    @(negedge clk); PCsrc = 1'b0; ImmOp = '0; #1;
    chk("o_valid", {31'd0, valid_o}, 32'd0);
    chk("o_req", {31'd0, imem_req}, 32'd1);
    chk("o_addr", imem_addr, 32'h8);
    @(negedge clk); #1;
    // Q: word at 8 live; stall it and switch to 3-cycle memory
    @(negedge clk); stall = 1'b1; lat = 3; #1;
    chk("q_valid", {31'd0, valid_o}, 32'd1);
    chk("q_instr", instr_o, 32'hAAAA_0003);
    chk("q_pc", pc_o, 32'h8);
    chk("q_addr", imem_addr, 32'hC);
    // R: redirect in WAIT with stall asserted -> redirect wins, go to DRAIN
    @(negedge clk); PCsrc = 1'b1; ImmOp = 32'h20; #1;
    chk("r_valid", {31'd0, valid_o}, 32'd1);
    chk("r_req", {31'd0, imem_req}, 32'd0);
    // S: IF/ID cleared, draining
    @(negedge clk); PCsrc = 1'b0; ImmOp = '0; stall = 1'b0; #1;
    chk("s_valid", {31'd0, valid_o}, 32'd0);
    chk("s_req", {31'd0, imem_req}, 32'd0);
    // T: late response arrives and is dropped
    @(negedge clk); #1;
    chk("t_valid", {31'd0, valid_o}, 32'd0);
    chk("t_req", {31'd0, imem_req}, 32'd0);
    // U: fetch at target; PCsrc with valid_o=0 is ignored
    @(negedge clk); PCsrc = 1'b1; ImmOp = 32'h100; lat = 1; #1;
    chk("u_valid", {31'd0, valid_o}, 32'd0);
    chk("u_req", {31'd0, imem_req}, 32'd1);
    chk("u_addr", imem_addr, 32'h28);
    @(negedge clk); #1;
    // W: word from target loaded despite PCsrc having been high
    @(negedge clk); PCsrc = 1'b0; ImmOp = '0; lat = 3; #1;
    chk("w_valid", {31'd0, valid_o}, 32'd1);
    chk("w_instr", instr_o, 32'hAAAA_000B);
    chk("w_pc", pc_o, 32'h28);
    chk("w_addr", imem_addr, 32'h2C);
    // X: reset while waiting on a slow response
    @(negedge clk); rst = 1'b1; #1;
    chk("x_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #1;
    chk("y_valid", {31'd0, valid_o}, 32'd0);
    chk("y_instr", instr_o, 32'h0000_0013);
    chk("y_pc", pc_o, 32'h0);
    chk("y_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); rst = 1'b0; lat = 1; #1;
    chk("z_req", {31'd0, imem_req}, 32'd1);
    chk("z_addr", imem_addr, 32'h0);
    @(negedge clk); #1;
    chk("aa_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("ab_valid", {31'd0, valid_o}, 32'd1);
    chk("ab_instr", instr_o, 32'hAAAA_0001);
    chk("ab_pc", pc_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
